// File: rtl/m_ucode_loader.sv
// m_ucode_loader: writer side of the midgetv microcode store.
// Packs a byte stream into little-endian 48-bit words and writes them at
// consecutive addresses. The core stays held until a load completes cleanly.
// Optional build macro: M_UCODE_LOADER_CHECKSUM_EN adds a trailing XOR
// checksum byte and the CHECK state. Without it, err is tied to 0.
//
// state   | meaning
// IDLE    | after reset, nothing loaded yet
// COLLECT | accepting the bytes of the current word
// WRITE   | one-cycle write strobe for the assembled word
// CHECK   | accepting the trailing checksum byte (checksum build only)
// DONE    | store loaded, core released
// ERR     | checksum mismatch, core held
module m_ucode_loader #(
   parameter int NWORDS = 256
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [7:0]  s_dat,
   input  logic        s_valid,
   output logic        s_ready,
   output logic [7:0]  wr_adr,
   output logic [47:0] wr_dat,
   output logic        wr_en,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic        hold_cpu
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_COLLECT = 3'd1,
      S_WRITE   = 3'd2,
`ifdef M_UCODE_LOADER_CHECKSUM_EN
      S_CHECK   = 3'd3,
`endif
      S_DONE    = 3'd4,
      S_ERR     = 3'd5
   } state_t;

   localparam logic [7:0] LAST_ADR = 8'(NWORDS - 1);

   state_t      state_q, state_d;
   logic [7:0]  adr_q;
   logic [2:0]  byte_idx_q;
   logic        xfer;
   logic        restart;

   assign xfer    = s_valid && s_ready;
   assign restart = start && (state_q == S_IDLE || state_q == S_DONE || state_q == S_ERR);

`ifdef M_UCODE_LOADER_CHECKSUM_EN
   logic [7:0] xor_q;

   // Running XOR of every word byte; cleared when a new load begins.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         xor_q <= 8'h00;
      end else if (restart) begin
         xor_q <= 8'h00;
      end else if (state_q == S_COLLECT && xfer) begin
         xor_q <= xor_q ^ s_dat;
      end
   end
`endif

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; start is only honoured outside an active load.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE, S_DONE, S_ERR: begin
            if (start) state_d = S_COLLECT;
         end
         S_COLLECT: begin
            if (xfer && byte_idx_q == 3'd5) state_d = S_WRITE;
         end
         S_WRITE: begin
            if (adr_q == LAST_ADR) begin
`ifdef M_UCODE_LOADER_CHECKSUM_EN
               state_d = S_CHECK;
`else
               state_d = S_DONE;
`endif
            end else begin
               state_d = S_COLLECT;
            end
         end
`ifdef M_UCODE_LOADER_CHECKSUM_EN
         S_CHECK: begin
            if (xfer) state_d = ((xor_q ^ s_dat) == 8'h00) ? S_DONE : S_ERR;
         end
`endif
         default: state_d = S_IDLE;
      endcase
   end

   // Word assembly and address counter; wr_dat keeps its value outside WRITE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         adr_q      <= 8'h00;
         byte_idx_q <= 3'd0;
         wr_dat     <= 48'h0;
      end else if (restart) begin
         adr_q      <= 8'h00;
         byte_idx_q <= 3'd0;
      end else begin
         if (state_q == S_COLLECT && xfer) begin
            for (int k = 0; k < 6; k++) begin
               if (byte_idx_q == 3'(k)) wr_dat[8*k +: 8] <= s_dat;
            end
            byte_idx_q <= (byte_idx_q == 3'd5) ? 3'd0 : byte_idx_q + 3'd1;
         end
         if (state_q == S_WRITE) adr_q <= adr_q + 8'd1;
      end
   end

   assign wr_adr   = adr_q;
   assign wr_en    = (state_q == S_WRITE);
   assign done     = (state_q == S_DONE);
   assign hold_cpu = (state_q != S_DONE);
`ifdef M_UCODE_LOADER_CHECKSUM_EN
   assign s_ready  = (state_q == S_COLLECT) || (state_q == S_CHECK);
   assign busy     = (state_q == S_COLLECT) || (state_q == S_WRITE) || (state_q == S_CHECK);
   assign err      = (state_q == S_ERR);
`else
   assign s_ready  = (state_q == S_COLLECT);
   assign busy     = (state_q == S_COLLECT) || (state_q == S_WRITE);
   assign err      = 1'b0;
`endif

endmodule

// File: tb/tb_m_ucode_loader.sv
// Directed bench for m_ucode_loader: a 256-word instance and a 1-word instance
// share clock and reset; the inputs are steered to one instance at a time.
module tb_m_ucode_loader;

`ifdef M_UCODE_LOADER_CHECKSUM_EN
   localparam int EXTRA = 2;
`else
   localparam int EXTRA = 1;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, start, s_valid, sel;
   logic [7:0]  s_dat;
   int          cyc = 0, t_start = 0, n_asrt = 0, n_fail = 0;

   logic        start_a, s_valid_a, s_ready_a, wr_en_a, busy_a, done_a, err_a, hold_a;
   logic [7:0]  wr_adr_a;
   logic [47:0] wr_dat_a;
   logic        start_b, s_valid_b, s_ready_b, wr_en_b, busy_b, done_b, err_b, hold_b;
   logic [7:0]  wr_adr_b;
   logic [47:0] wr_dat_b;
   logic        rdy, cur_end;

   assign start_a   = start   && !sel;
   assign s_valid_a = s_valid && !sel;
   assign start_b   = start   && sel;
   assign s_valid_b = s_valid && sel;
   assign rdy       = sel ? s_ready_b : s_ready_a;
   assign cur_end   = sel ? (done_b || err_b) : (done_a || err_a);

   m_ucode_loader #(.NWORDS(256)) dut_a (
      .clk(clk), .rst_n(rst_n), .start(start_a), .s_dat(s_dat), .s_valid(s_valid_a),
      .s_ready(s_ready_a), .wr_adr(wr_adr_a), .wr_dat(wr_dat_a), .wr_en(wr_en_a),
      .busy(busy_a), .done(done_a), .err(err_a), .hold_cpu(hold_a));

   m_ucode_loader #(.NWORDS(1)) dut_b (
      .clk(clk), .rst_n(rst_n), .start(start_b), .s_dat(s_dat), .s_valid(s_valid_b),
      .s_ready(s_ready_b), .wr_adr(wr_adr_b), .wr_dat(wr_dat_b), .wr_en(wr_en_b),
      .busy(busy_b), .done(done_b), .err(err_b), .hold_cpu(hold_b));

   function automatic logic [47:0] exp_word(input logic [7:0] a);
      logic [47:0] w;
      int j;
      w = '0;
      for (int k = 0; k < 6; k++) begin
         j = 6 * int'(a) + k;
         w[8*k +: 8] = j[7:0];
      end
      return w;
   endfunction

   // Cycle counter for latency measurements.
   always @(posedge clk) cyc <= cyc + 1;

   int          wr_tot_a = 0, wr_bad_a = 0, err_seen_a = 0, wr_tot_b = 0;
   logic [7:0]  nxt_adr_a = 8'h00, last_adr_a = 8'h00;
   logic [47:0] last_dat_a = '0, w0_a = '0, w1_a = '0;

   // Write-port monitor for the 256-word instance: address order and data.
   always @(negedge clk) begin
      if (!rst_n) begin
         nxt_adr_a <= 8'h00;
      end else if (wr_en_a) begin
         if (wr_adr_a !== nxt_adr_a || wr_dat_a !== exp_word(wr_adr_a)) wr_bad_a <= wr_bad_a + 1;
         nxt_adr_a  <= wr_adr_a + 8'd1;
         wr_tot_a   <= wr_tot_a + 1;
         last_adr_a <= wr_adr_a;
         last_dat_a <= wr_dat_a;
         if (wr_adr_a == 8'h00) w0_a <= wr_dat_a;
         if (wr_adr_a == 8'h01) w1_a <= wr_dat_a;
      end
      if (err_a) err_seen_a <= err_seen_a + 1;
   end

   // Write counter for the 1-word instance.
   always @(negedge clk) begin
      if (wr_en_b) wr_tot_b <= wr_tot_b + 1;
   end

   task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
      n_asrt++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input int ncyc);
      start   = 1'b1;
      t_start = cyc;
      repeat (ncyc) tick();
      start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      int n;
      if (gap > 0) begin
         s_valid = 1'b0;
         repeat (gap) tick();
      end
      s_dat   = b;
      s_valid = 1'b1;
      n = 0;
      while (!rdy && n < 20) begin
         tick();
         n++;
      end
      if (!rdy) chk("ready_timeout", 48'(rdy), 48'h1);
      tick();
   endtask

   task automatic send_stream(input int nbytes, input bit with_ck, input logic [7:0] ck_flip,
                              input int maxgap);
      logic [7:0] x, b;
      x = 8'h00;
      for (int j = 0; j < nbytes; j++) begin
         b = j[7:0];
         x = x ^ b;
         send_byte(b, (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
      end
`ifdef M_UCODE_LOADER_CHECKSUM_EN
      if (with_ck) send_byte(x ^ ck_flip, 0);
`endif
      s_valid = 1'b0;
   endtask

   task automatic wait_end(output int dt);
      int n;
      n = 0;
      while (!cur_end && n < 5000) begin
         tick();
         n++;
      end
      if (!cur_end) chk("end_timeout", 48'(cur_end), 48'h1);
      dt = cyc - t_start;
   endtask

   task automatic chk_reset_a(input string pre);
      chk({pre, "_s_ready"}, 48'(s_ready_a), 48'h0);
      chk({pre, "_wr_en"},   48'(wr_en_a),   48'h0);
      chk({pre, "_wr_adr"},  48'(wr_adr_a),  48'h0);
      chk({pre, "_wr_dat"},  wr_dat_a,       48'h0);
      chk({pre, "_busy"},    48'(busy_a),    48'h0);
      chk({pre, "_done"},    48'(done_a),    48'h0);
      chk({pre, "_err"},     48'(err_a),     48'h0);
      chk({pre, "_hold"},    48'(hold_a),    48'h1);
   endtask

   initial begin
      int dt, base_tot, base_bad;
      sel = 1'b0; start = 1'b0; s_valid = 1'b0; s_dat = 8'h00; rst_n = 1'b0;
      #12;
      chk_reset_a("rst");
      tick();
      rst_n = 1'b1;
      tick();

      // Full gap-free load; busy and s_ready one cycle after start.
      base_tot = wr_tot_a; base_bad = wr_bad_a;
      do_start(1);
      chk("start_busy",  48'(busy_a),    48'h1);
      chk("start_ready", 48'(s_ready_a), 48'h1);
      send_stream(6 * 256, 1'b1, 8'h00, 0);
      wait_end(dt);
      chk("full_cycles",   48'(dt), 48'(7 * 256 + EXTRA));
      chk("full_writes",   48'(wr_tot_a - base_tot), 48'd256);
      chk("full_bad",      48'(wr_bad_a - base_bad), 48'd0);
      chk("full_word0",    w0_a, 48'h050403020100);
      chk("full_word1",    w1_a, 48'h0B0A09080706);
      chk("full_last_adr", 48'(last_adr_a), 48'hFF);
      chk("full_last_dat", last_dat_a, 48'hFFFEFDFCFBFA);
      chk("full_done",     48'(done_a), 48'h1);
      chk("full_hold",     48'(hold_a), 48'h0);
      chk("full_err",      48'(err_a),  48'h0);
      chk("full_busy",     48'(busy_a), 48'h0);
      chk("full_adr_wrap", 48'(wr_adr_a), 48'h0);

      // Backpressure with start held three cycles.
      base_tot = wr_tot_a; base_bad = wr_bad_a;
      do_start(3);
      send_stream(6 * 256, 1'b1, 8'h00, 3);
      wait_end(dt);
      chk("bp_writes", 48'(wr_tot_a - base_tot), 48'd256);
      chk("bp_bad",    48'(wr_bad_a - base_bad), 48'd0);
      chk("bp_done",   48'(done_a), 48'h1);

`ifdef M_UCODE_LOADER_CHECKSUM_EN
      // Corrupted checksum, then a clean reload.
      base_tot = wr_tot_a;
      do_start(1);
      send_stream(6 * 256, 1'b1, 8'h01, 0);
      wait_end(dt);
      chk("ck_writes", 48'(wr_tot_a - base_tot), 48'd256);
      chk("ck_err",    48'(err_a),  48'h1);
      chk("ck_done",   48'(done_a), 48'h0);
      chk("ck_hold",   48'(hold_a), 48'h1);
      do_start(1);
      chk("ck_restart_err",  48'(err_a),  48'h0);
      chk("ck_restart_busy", 48'(busy_a), 48'h1);
      send_stream(6 * 256, 1'b1, 8'h00, 0);
      wait_end(dt);
      chk("ck_clean_done", 48'(done_a), 48'h1);
      chk("ck_clean_err",  48'(err_a),  48'h0);
`else
      chk("nock_err_never", 48'(err_seen_a), 48'd0);
`endif

      // Single-word instance.
      sel = 1'b1;
      base_tot = wr_tot_b;
      do_start(1);
      send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0);
      send_byte(8'h44, 0); send_byte(8'h55, 0); send_byte(8'h66, 0);
      chk("one_wr_en",  48'(wr_en_b),   48'h1);
      chk("one_ready",  48'(s_ready_b), 48'h0);
      chk("one_adr",    48'(wr_adr_b),  48'h0);
      chk("one_dat",    wr_dat_b,       48'h665544332211);
      tick();
`ifdef M_UCODE_LOADER_CHECKSUM_EN
      chk("one_ck_ready", 48'(s_ready_b), 48'h1);
      send_byte(8'h77, 0);
`else
      chk("one_done_after_write", 48'(done_b), 48'h1);
`endif
      s_valid = 1'b0;
      wait_end(dt);
      chk("one_cycles", 48'(dt), 48'(7 + EXTRA));
      chk("one_writes", 48'(wr_tot_b - base_tot), 48'd1);
      chk("one_done",   48'(done_b), 48'h1);
      chk("one_hold",   48'(hold_b), 48'h0);
      chk("one_err",    48'(err_b),  48'h0);
      sel = 1'b0;

      // Reset mid-load after word 17 byte 3, then reload from scratch.
      do_start(1);
      send_stream(17 * 6 + 4, 1'b0, 8'h00, 0);
      chk("mid_busy", 48'(busy_a), 48'h1);
      #3;
      rst_n = 1'b0;
      #1;
      chk_reset_a("async");
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      base_tot = wr_tot_a; base_bad = wr_bad_a;
      do_start(1);
      send_stream(6 * 256, 1'b1, 8'h00, 0);
      wait_end(dt);
      chk("rl_cycles", 48'(dt), 48'(7 * 256 + EXTRA));
      chk("rl_writes", 48'(wr_tot_a - base_tot), 48'd256);
      chk("rl_bad",    48'(wr_bad_a - base_bad), 48'd0);
      chk("rl_word0",  w0_a, 48'h050403020100);
      chk("rl_done",   48'(done_a), 48'h1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
      $finish;
   end

endmodule

// File: doc/m_ucode_loader.md
# m_ucode_loader

Writer side of the midgetv microcode store. It accepts a byte stream over a valid/ready handshake and assembles each run of six bytes into a 48-bit microcode word. Each word is written into the ucode EBR write port at consecutive addresses. The CPU is held (the `progress_ucode` path is gated) until the store has been completely and correctly loaded. The block sits between the boot source (SPI-flash reader or debug UART) and the write port of the microcode RAM that `m_ucode` reads.

## Interface
- `NWORDS`, 256: number of microcode words loaded per `start`. Legal range is 1..256.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  single-cycle request to begin a load.
- `s_dat`  in  8  stream byte.
- `s_valid`  in  1  `s_dat` is valid.
- `s_ready`  out  1  loader accepts a byte this cycle.
- `wr_adr`  out  8  ucode RAM write address.
- `wr_dat`  out  48  ucode RAM write data.
- `wr_en`  out  1  ucode RAM write strobe, one cycle per word.
- `busy`  out  1  a load is in progress.
- `done`  out  1  last load completed successfully.
- `err`  out  1  last load failed its checksum.
- `hold_cpu`  out  1  stall request to the core; ANDed low into `progress_ucode` upstream.

## Operation
- A byte transfer occurs when `s_valid && s_ready` on a rising edge. `s_dat` is ignored at all other times.
- States: IDLE, COLLECT, WRITE, CHECK, DONE, ERR.
- **IDLE / DONE / ERR → COLLECT** on `start`. Entering COLLECT clears the word address, byte index, `done`, `err` and the checksum.
- **`start` in COLLECT, WRITE or CHECK** is ignored.
- **COLLECT:** `s_ready`=1.
  - The byte with index k (0..5) lands in `wr_dat[8k+7:8k]`, so the word is little-endian.
  - When byte 5 is accepted, the next state is WRITE.
- **WRITE:** `s_ready`=0 and `wr_en`=1 for exactly one cycle, with `wr_adr` = current word address.
  - Then the address increments.
  - If the address was NWORDS-1, the next state is CHECK (macro defined) or DONE (macro undefined). Otherwise the next state is COLLECT.
- **CHECK:** `s_ready`=1. One trailing byte is accepted.
  - Next state is DONE if the running XOR over all stream bytes, including this one, equals 8'h00; otherwise ERR.
- **DONE:** `done`=1, `hold_cpu`=0, holds until the next `start`.
- **ERR:** `err`=1, `hold_cpu`=1, holds until the next `start`.
- `busy` = 1 in COLLECT, WRITE and CHECK.
- `hold_cpu` = 1 in every state except DONE. The CPU therefore never runs from an unloaded or corrupt store.
- Word address is 8 bits wide. With NWORDS=256 the final WRITE is at 8'hFF and the counter wraps to 0 without any further write.
- `wr_dat` holds its value outside WRITE. Only `wr_en` qualifies it.

## Timing
- Reset values (asynchronous on `rst_n`=0):
  - state = IDLE
  - `s_ready`=0, `wr_en`=0, `wr_adr`=8'h00, `wr_dat`=48'h0
  - `busy`=0, `done`=0, `err`=0, `hold_cpu`=1
- All outputs are registered or decoded from registered state only. There is no combinational path from `s_valid` to `s_ready`.
- `start` in cycle n gives `busy`=1 and `s_ready`=1 in cycle n+1.
- Sixth byte accepted in cycle n gives `wr_en`=1 in cycle n+1 and `s_ready`=1 again in cycle n+2.
- Minimum load time with no stream stalls:
  - 7·NWORDS + 1 cycles after `start` (macro undefined).
  - 7·NWORDS + 2 cycles after `start` (macro defined).
- Stalls (`s_valid`=0) have no limit. Partial word state is held indefinitely.
- Reset asserted mid-load aborts immediately. RAM contents written so far are undefined for the core, and `hold_cpu` stays 1.

## Configuration
- `M_UCODE_LOADER_CHECKSUM_EN` defined:
  - A trailing checksum byte is expected and the CHECK state exists.
  - On mismatch the block ends in ERR with `err`=1.
- Macro undefined:
  - The CHECK state and the XOR register are compiled out.
  - The last WRITE goes directly to DONE and `err` is tied to 0.

## Test plan
- **Full load, checksum enabled:** NWORDS=256, stream with byte j = j[7:0] plus the correct checksum byte.
  - Expect 256 `wr_en` pulses, adr 0..255.
  - Expect word 0 = 48'h050403020100 and word 1 = 48'h0B0A09080706.
  - End state: `done`=1, `hold_cpu`=0, `err`=0.
- **Backpressure and gaps:** random `s_valid` deassertion and `start` held for 3 cycles.
  - Expect written words identical to the gap-free run.
  - Extra `start` cycles are ignored and exactly 256 writes occur.
- **Checksum error:** same stream with the checksum byte XORed by 8'h01.
  - End state: `err`=1, `done`=0, `hold_cpu`=1.
  - A new `start` clears `err` and a clean stream reaches DONE.
- **Edge size:** NWORDS=1, bytes 11,22,33,44,55,66 (+checksum 8'h77).
  - Expect a single write: adr 0, data 48'h665544332211.
  - `done` rises 9 cycles after `start` (8 with the macro undefined).
- **Reset mid-load:** `rst_n` pulsed low after word 17, byte 3.
  - Expect all outputs at their reset values asynchronously.
  - A restart loads from adr 0 with byte index 0.
- **Macro undefined build:** stream of 6·NWORDS bytes only.
  - Expect DONE immediately after the last WRITE.
  - `err` stays 0 throughout.
